// File: rtl/complex_vxc_chunk_sequencer_pkg.sv
// Shared definitions for the complex vector-times-constant chunk sequencer:
// default element width and lane count, FSM state encoding, and helpers that
// derive the chunk count, address width and last-chunk lane mask.
package complex_vxc_chunk_sequencer_pkg;

  localparam int unsigned ElementWidth = 64;
  localparam int unsigned DefaultNi    = 8;
  localparam int unsigned MaxNi        = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } seq_state_e;

  // Chunks needed to cover noe elements; no spare chunk when noe is a multiple of ni.
  function automatic int unsigned calc_nch(input int unsigned noe, input int unsigned ni);
    return (noe + ni - 1) / ni;
  endfunction

  // A single-chunk vector still needs a 1-bit address port.
  function automatic int unsigned calc_addr_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Lane mask for the last chunk, bit ni-1 is lane 0; padding lanes are 0.
  function automatic logic [MaxNi-1:0] last_chunk_mask(input int unsigned noe,
                                                       input int unsigned ni);
    int unsigned      live;
    logic [MaxNi-1:0] mask;
    live = noe - (calc_nch(noe, ni) - 1) * ni;
    mask = '0;
    for (int unsigned j = 0; j < ni; j++) begin
      if (j < live) mask = mask | (MaxNi'(1) << (ni - 1 - j));
    end
    return mask;
  endfunction

endpackage

// File: rtl/complex_vxc_chunk_sequencer_tag_delay.sv
// chunk_tag_delay: LAT-deep shift register carrying {valid, chunk address}
// alongside each chunk in flight through the downstream stage.
// Ports: clk, reset (async active-low), in_valid/in_addr (tag entering the
// stage), out_valid/out_addr (same tag exactly LAT cycles later).
module chunk_tag_delay #(
  parameter int unsigned LAT = 8,
  parameter int unsigned AW  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  logic [LAT-1:0] valid_q;
  logic [AW-1:0]  addr_q [LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_addr  = addr_q[LAT-1];

endmodule

// File: rtl/complex_vxc_chunk_sequencer.sv
// Sequences one vector pass through a fixed-latency vector-times-constant
// add stage: reads every chunk from memory, drives the stage with padded
// rows plus the latched constant/op, and writes each result back LAT cycles
// after it was issued.
// Ports: clk, reset (async active-low); start/op_in/constant_in (pass
// request); rd_en/rd_addr/first_rd_data/second_rd_data (chunk read, 1-cycle
// latency); first_row_input/second_row_input/constant/op/stage_valid (stage
// drive); result (stage output); wr_en/wr_addr/wr_data/wr_mask (write-back);
// busy, done (one-cycle end-of-pass pulse).
module complex_vxc_chunk_sequencer
  import complex_vxc_chunk_sequencer_pkg::*;
#(
  parameter int unsigned NOE           = 19,
  parameter int unsigned NI            = DefaultNi,
  parameter int unsigned element_width = ElementWidth,
  parameter int unsigned LAT           = 8,
  localparam int unsigned NCH          = calc_nch(NOE, NI),
  localparam int unsigned AW           = calc_addr_width(NCH),
  localparam int unsigned W            = element_width * NI
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op_in,
  input  logic [element_width-1:0] constant_in,
  output logic                     rd_en,
  output logic [AW-1:0]            rd_addr,
  input  logic [W-1:0]             first_rd_data,
  input  logic [W-1:0]             second_rd_data,
  output logic [W-1:0]             first_row_input,
  output logic [W-1:0]             second_row_input,
  output logic [element_width-1:0] constant,
  output logic                     op,
  output logic                     stage_valid,
  input  logic [W-1:0]             result,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [W-1:0]             wr_data,
  output logic [NI-1:0]            wr_mask,
  output logic                     busy,
  output logic                     done
);

  localparam logic [AW-1:0] LastAddr = AW'(NCH - 1);
  localparam logic [NI-1:0] LastMask = NI'(last_chunk_mask(NOE, NI));

  seq_state_e    state_q;
  logic          rd_vld_q;      // read data is on the bus this cycle
  logic [AW-1:0] rd_addr_d1_q;  // address that data belongs to
  logic [AW-1:0] stage_addr_q;
  logic          rd_last;
  logic          tag_valid;
  logic [AW-1:0] tag_addr;
  logic [W-1:0]  first_keep;
  logic [W-1:0]  second_keep;

  assign rd_last = (rd_addr_d1_q == LastAddr);

  // Padding lanes of the last chunk are forced to zero before the stage.
  for (genvar j = 0; j < NI; j++) begin : g_lane
    localparam int unsigned Hi = (NI - j) * element_width - 1;
    assign first_keep[Hi -: element_width] =
        (rd_last && !LastMask[NI-1-j]) ? '0 : first_rd_data[Hi -: element_width];
    assign second_keep[Hi -: element_width] =
        (rd_last && !LastMask[NI-1-j]) ? '0 : second_rd_data[Hi -: element_width];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      op       <= 1'b0;
      constant <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StIssue;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            rd_addr  <= '0;
            op       <= op_in;
            constant <= constant_in;
          end
        end
        StIssue: begin
          if (rd_addr == LastAddr) begin
            state_q <= StDrain;
            rd_en   <= 1'b0;
            rd_addr <= '0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        StDrain: begin
          if (tag_valid && (tag_addr == LastAddr)) begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_q         <= 1'b0;
      rd_addr_d1_q     <= '0;
      stage_valid      <= 1'b0;
      stage_addr_q     <= '0;
      first_row_input  <= '0;
      second_row_input <= '0;
    end else begin
      rd_vld_q         <= rd_en;
      rd_addr_d1_q     <= rd_addr;
      stage_valid      <= rd_vld_q;
      stage_addr_q     <= rd_addr_d1_q;
      first_row_input  <= rd_vld_q ? first_keep : '0;
      second_row_input <= rd_vld_q ? second_keep : '0;
    end
  end

  chunk_tag_delay #(
    .LAT(LAT),
    .AW (AW)
  ) u_tag_delay (
    .clk      (clk),
    .reset    (reset),
    .in_valid (stage_valid),
    .in_addr  (stage_addr_q),
    .out_valid(tag_valid),
    .out_addr (tag_addr)
  );

  assign wr_en   = tag_valid;
  assign wr_addr = tag_valid ? tag_addr : '0;
  assign wr_data = tag_valid ? result : '0;
  assign wr_mask = !tag_valid ? '0 : ((tag_addr == LastAddr) ? LastMask : '1);

endmodule

// File: tb/tb_complex_vxc_chunk_sequencer.sv
module tb_complex_vxc_chunk_sequencer;

  localparam int NOE = 19;
  localparam int NI  = 8;
  localparam int EW  = 64;
  localparam int LAT = 8;
  localparam int NCH = (NOE + NI - 1) / NI;
  localparam int AW  = 2;
  localparam int W   = EW * NI;
  localparam int NOE_B = 16;
  localparam int AW_B  = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          op_in = 1'b0;
  logic [EW-1:0] constant_in = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  first_rd_data = '0;
  logic [W-1:0]  second_rd_data = '0;
  logic [W-1:0]  first_row_input, second_row_input, result, wr_data;
  logic [EW-1:0] constant;
  logic          op, stage_valid, wr_en, busy, done;
  logic [AW-1:0] wr_addr;
  logic [NI-1:0] wr_mask;

  logic            start_b = 1'b0;
  logic            rd_en_b, op_b, stage_valid_b, wr_en_b, busy_b, done_b;
  logic [AW_B-1:0] rd_addr_b, wr_addr_b;
  logic [W-1:0]    first_row_b, second_row_b, wr_data_b;
  logic [EW-1:0]   constant_b;
  logic [NI-1:0]   wr_mask_b;
  logic [W-1:0]    rd_data_b = {NI{64'h0000_0001_0000_0002}};
  logic [W-1:0]    result_b = '0;

  always #5 clk = ~clk;

  complex_vxc_chunk_sequencer #(
    .NOE(NOE), .NI(NI), .element_width(EW), .LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op_in(op_in), .constant_in(constant_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .first_rd_data(first_rd_data),
    .second_rd_data(second_rd_data), .first_row_input(first_row_input),
    .second_row_input(second_row_input), .constant(constant), .op(op),
    .stage_valid(stage_valid), .result(result), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .busy(busy), .done(done)
  );

  complex_vxc_chunk_sequencer #(
    .NOE(NOE_B), .NI(NI), .element_width(EW), .LAT(LAT)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .op_in(1'b0), .constant_in(64'd5),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .first_rd_data(rd_data_b),
    .second_rd_data(rd_data_b), .first_row_input(first_row_b),
    .second_row_input(second_row_b), .constant(constant_b), .op(op_b),
    .stage_valid(stage_valid_b), .result(result_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .wr_mask(wr_mask_b), .busy(busy_b), .done(done_b)
  );

  // Chunk memory with 1-cycle read latency; padding lanes hold garbage.
  logic [W-1:0] mem_f [4];
  logic [W-1:0] mem_s [4];
  always @(posedge clk) begin
    if (rd_en) begin
      first_rd_data  <= mem_f[rd_addr];
      second_rd_data <= mem_s[rd_addr];
    end
  end

  // Lane-wise reference stage: op ? a - b + c : a + b + c.
  function automatic logic [W-1:0] stage_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [EW-1:0] c, input logic o);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < NI; j++) begin
      r[(NI-j)*EW-1 -: EW] = o ? (a[(NI-j)*EW-1 -: EW] - b[(NI-j)*EW-1 -: EW] + c)
                               : (a[(NI-j)*EW-1 -: EW] + b[(NI-j)*EW-1 -: EW] + c);
    end
    return r;
  endfunction

  // Emulated downstream stage with LAT cycles of latency.
  logic [W-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= stage_fn(first_row_input, second_row_input, constant, op);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign result = pipe[LAT-1];

  // Reference model state.
  int            cyc = 0;
  bit            pass_v = 1'b0;
  int            pass_s = 0;
  int            next_ok = 0;
  bit            latch_v = 1'b0;
  int            latch_cyc = 0;
  logic          cur_op = 1'b0, prev_op = 1'b0;
  logic [EW-1:0] cur_c = '0, prev_c = '0;
  logic [EW-1:0] ef [NOE];
  logic [EW-1:0] es [NOE];

  int n_checks = 0;
  int n_fail = 0;
  int wr_log[$];
  int rd_log[$];
  int sv_log[$];
  int done_log[$];
  logic [W-1:0]  last_row_f, last_row_s;
  logic [NI-1:0] last_wmask;
  int nwr_b = 0, nrd_b = 0, ndone_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] chunk_of(input bit sec, input int k);
    logic [W-1:0] w;
    w = '0;
    for (int j = 0; j < NI; j++) begin
      if (k * NI + j < NOE) w[(NI-j)*EW-1 -: EW] = sec ? es[k*NI+j] : ef[k*NI+j];
    end
    return w;
  endfunction

  function automatic logic [NI-1:0] exp_mask(input int k);
    logic [NI-1:0] m;
    m = '0;
    for (int j = 0; j < NI; j++) m[NI-1-j] = (k * NI + j < NOE);
    return m;
  endfunction

  always @(negedge clk) begin : compare
    int d;
    logic e_rd, e_sv, e_wr, e_busy, e_done, e_op;
    logic [EW-1:0] e_c;
    d      = pass_v ? (cyc - pass_s) : -1;
    e_rd   = (d >= 1) && (d <= NCH);
    e_sv   = (d >= 3) && (d <= NCH + 2);
    e_wr   = (d >= LAT + 3) && (d <= LAT + 2 + NCH);
    e_done = (d == LAT + 3 + NCH);
    e_busy = (d >= 1) && (d <= LAT + 3 + NCH);
    e_op   = (latch_v && cyc > latch_cyc) ? cur_op : prev_op;
    e_c    = (latch_v && cyc > latch_cyc) ? cur_c : prev_c;
    chk("rd_en", W'(rd_en), W'(e_rd));
    if (e_rd || !reset) chk("rd_addr", W'(rd_addr), e_rd ? W'(d - 1) : '0);
    chk("stage_valid", W'(stage_valid), W'(e_sv));
    if (e_sv) begin
      chk("first_row", first_row_input, chunk_of(1'b0, d - 3));
      chk("second_row", second_row_input, chunk_of(1'b1, d - 3));
    end
    chk("wr_en", W'(wr_en), W'(e_wr));
    if (e_wr) begin
      chk("wr_addr", W'(wr_addr), W'(d - LAT - 3));
      chk("wr_data", wr_data,
          stage_fn(chunk_of(1'b0, d - LAT - 3), chunk_of(1'b1, d - LAT - 3), cur_c, cur_op));
      chk("wr_mask", W'(wr_mask), W'(exp_mask(d - LAT - 3)));
    end
    if (!reset) begin
      chk("rst_first_row", first_row_input, '0);
      chk("rst_second_row", second_row_input, '0);
      chk("rst_wr_data", wr_data, '0);
      chk("rst_wr_addr", W'(wr_addr), '0);
    end
    chk("busy", W'(busy), W'(e_busy));
    chk("done", W'(done), W'(e_done));
    chk("op", W'(op), W'(e_op));
    chk("constant", W'(constant), W'(e_c));
    if (wr_en) begin
      wr_log.push_back(cyc);
      last_wmask = wr_mask;
    end
    if (rd_en) rd_log.push_back(cyc);
    if (stage_valid) begin
      sv_log.push_back(cyc);
      last_row_f = first_row_input;
      last_row_s = second_row_input;
    end
    if (done) done_log.push_back(cyc);
    // NOE=16 instance: every chunk is full and written in address order.
    if (wr_en_b) begin
      chk("b_wr_mask", W'(wr_mask_b), W'(8'hFF));
      chk("b_wr_addr", W'(wr_addr_b), W'(nwr_b));
      nwr_b++;
    end
    if (rd_en_b) nrd_b++;
    if (done_b) ndone_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic try_start(input logic o, input logic [EW-1:0] c);
    start       = 1'b1;
    op_in       = o;
    constant_in = c;
    if (reset && cyc >= next_ok) begin
      pass_v    = 1'b1;
      pass_s    = cyc;
      next_ok   = cyc + 4 + LAT + NCH;
      if (latch_v && cyc > latch_cyc) begin
        prev_op = cur_op;
        prev_c  = cur_c;
      end
      latch_v   = 1'b1;
      latch_cyc = cyc;
      cur_op    = o;
      cur_c     = c;
      for (int i = 0; i < NOE; i++) begin
        ef[i] = {$urandom, $urandom};
        es[i] = {$urandom, $urandom};
      end
      for (int k = 0; k < NCH; k++) begin
        for (int j = 0; j < NI; j++) begin
          mem_f[k][(NI-j)*EW-1 -: EW] = (k * NI + j < NOE) ? ef[k*NI+j] : {$urandom, $urandom};
          mem_s[k][(NI-j)*EW-1 -: EW] = (k * NI + j < NOE) ? es[k*NI+j] : {$urandom, $urandom};
        end
      end
    end
    tick();
    start       = 1'b0;
    op_in       = $urandom_range(0, 1);
    constant_in = {$urandom, $urandom};
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    pass_v    = 1'b0;
    latch_v   = 1'b0;
    next_ok   = 0;
    cur_op    = 1'b0;
    prev_op   = 1'b0;
    cur_c     = '0;
    prev_c    = '0;
  endtask

  initial begin : driver
    int s0, mark_wr, mark_done;
    for (int k = 0; k < 4; k++) begin
      mem_f[k] = '0;
      mem_s[k] = '0;
    end
    apply_reset();
    repeat (3) tick();
    chk("reset_busy", W'(busy), '0);
    chk("reset_constant", W'(constant), '0);
    reset = 1'b1;
    tick();

    // Directed pass: op=0, constant 1.0 in the real half; restart attempt at +5.
    wr_log.delete(); rd_log.delete(); sv_log.delete(); done_log.delete();
    s0 = cyc;
    start_b = 1'b1;
    try_start(1'b0, 64'h3F800000_00000000);
    start_b = 1'b0;
    repeat (4) tick();
    try_start(1'b1, 64'h1234_5678_9ABC_DEF0);
    repeat (20) tick();
    chk("rd_count", W'(rd_log.size()), W'(3));
    if (rd_log.size() == 3) begin
      chk("rd_first_cyc", W'(rd_log[0] - s0), W'(1));
      chk("rd_last_cyc", W'(rd_log[2] - s0), W'(3));
    end
    chk("sv_count", W'(sv_log.size()), W'(3));
    if (sv_log.size() == 3) chk("sv_first_cyc", W'(sv_log[0] - s0), W'(3));
    chk("wr_count", W'(wr_log.size()), W'(3));
    if (wr_log.size() == 3) begin
      chk("wr_first_cyc", W'(wr_log[0] - s0), W'(11));
      chk("wr_last_cyc", W'(wr_log[2] - s0), W'(13));
    end
    chk("done_count", W'(done_log.size()), W'(1));
    if (done_log.size() == 1) chk("done_cyc", W'(done_log[0] - s0), W'(14));
    chk("last_mask_lit", W'(last_wmask), W'(8'b1110_0000));
    chk("pad_first_lit", W'(last_row_f[5*EW-1:0]), '0);
    chk("pad_second_lit", W'(last_row_s[5*EW-1:0]), '0);
    chk("op_hold_lit", W'(op), '0);
    chk("const_hold_lit", W'(constant), W'(64'h3F800000_00000000));
    chk("b_rd_count", W'(nrd_b), W'(2));
    chk("b_wr_count", W'(nwr_b), W'(2));
    chk("b_done_count", W'(ndone_b), W'(1));

    // Start coinciding with done is dropped; the next cycle is accepted.
    try_start(1'b1, {$urandom, $urandom});
    while (cyc < pass_s + LAT + 3 + NCH) tick();
    try_start(1'b0, {$urandom, $urandom});
    try_start(1'b0, {$urandom, $urandom});
    repeat (25) tick();

    // Reset at cycle 9 of a pass aborts it; the next pass is normal.
    try_start(1'b1, {$urandom, $urandom});
    while (cyc < pass_s + 9) tick();
    mark_wr   = wr_log.size();
    mark_done = done_log.size();
    apply_reset();
    repeat (3) tick();
    reset = 1'b1;
    repeat (25) tick();
    chk("abort_no_wr", W'(wr_log.size()), W'(mark_wr));
    chk("abort_no_done", W'(done_log.size()), W'(mark_done));
    try_start(1'b0, {$urandom, $urandom});
    repeat (25) tick();
    chk("after_abort_wr", W'(wr_log.size()), W'(mark_wr + 3));
    chk("after_abort_done", W'(done_log.size()), W'(mark_done + 1));

    // Random starts, many landing while busy.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) try_start(1'($urandom_range(0, 1)), {$urandom, $urandom});
      else tick();
    end
    repeat (25) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/complex_vxc_chunk_sequencer.md
COMPLEX_VXC_CHUNK_SEQUENCER -- requirements
Module: complex_vxc_chunk_sequencer

Interface
REQ-001 The block SHALL have parameter NOE, default 19, meaning number of complex elements per vector.
REQ-002 The block SHALL have parameter NI, default 8, meaning lanes per chunk.
REQ-003 The block SHALL have parameter element_width, default 64, meaning one complex element (real in [63:32], imag in [31:0]).
REQ-004 The block SHALL have parameter LAT, default 8, meaning the fixed latency in clocks from stage inputs to stage result.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle request to begin a vector pass.
REQ-008 The block SHALL have ports op_in (1 bit, 0 add / 1 subtract) and constant_in (element_width bits), inputs, both sampled with start.
REQ-009 The block SHALL have ports rd_en (output, 1), rd_addr (output, $clog2(NCH) bits), first_rd_data and second_rd_data (inputs, element_width*NI): chunk memory read port with 1-cycle read latency.
REQ-010 The block SHALL have ports first_row_input, second_row_input (outputs, element_width*NI), constant (output, element_width), op (output, 1) and stage_valid (output, 1): the drive to the downstream vector-times-constant add stage.
REQ-011 The block SHALL have port result, input, element_width*NI: the stage output.
REQ-012 The block SHALL have ports wr_en (output, 1), wr_addr (output, $clog2(NCH)), wr_data (output, element_width*NI) and wr_mask (output, NI): chunk write-back port.
REQ-013 The block SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-014 NCH SHALL equal ceil(NOE/NI); no extra chunk is added when NOE is a multiple of NI.
REQ-015 Lane j of chunk k SHALL hold element k*NI+j, with lane 0 in the most significant element_width bits.
REQ-016 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-017 IDLE->ISSUE SHALL occur on start=1; the block latches op_in and constant_in at that edge, and they stay constant until the next start.
REQ-018 In ISSUE, the block SHALL assert rd_en with rd_addr=k on consecutive cycles for k=0..NCH-1, then move to DRAIN.
REQ-019 Read data returned for address k SHALL be registered onto first_row_input and second_row_input, with stage_valid=1, one cycle after the data returns (two cycles after rd_en).
REQ-020 Padding lanes (index >= NOE in the last chunk) SHALL be driven with zero.
REQ-021 A LAT-deep shift register of {valid, address} SHALL track each chunk in flight.
REQ-022 Exactly LAT cycles after stage_valid for chunk k, the block SHALL assert wr_en=1 with wr_addr=k and wr_data=result.
REQ-023 wr_mask SHALL be all-ones, except that bits for padding lanes in the last chunk are 0 (bit NI-1 corresponds to lane 0).
REQ-024 DRAIN->DONE SHALL occur on the cycle of the write for chunk NCH-1.
REQ-025 DONE SHALL pulse done=1 for one cycle and then return to IDLE.
REQ-026 busy SHALL be 1 in the ISSUE, DRAIN and DONE states.
REQ-027 start while busy SHALL be ignored, with no effect on the current pass.
REQ-028 A start in the same cycle as done=1 SHALL be ignored; the earliest accepted start is the cycle after done.
REQ-029 For NCH=1, the block SHALL issue exactly one read and one write.

Reset
REQ-030 On reset=0, the block SHALL asynchronously enter IDLE and clear the shift register.
REQ-031 On reset=0, rd_en, wr_en, stage_valid, busy, done and op SHALL be 0, and all data/address outputs and constant SHALL be 0.
REQ-032 Reset mid-pass SHALL abort the pass: no further wr_en and no done until a new start after reset release.
REQ-033 The block SHALL synchronize reset deassertion to clk outside this block; the block only requires reset to be asynchronous-assert.

Structure
REQ-034 A shared package SHALL hold element_width, NI, the FSM state encoding and the NCH/last-chunk-mask computation functions.
REQ-035 The {valid, address} latency pipe SHALL be one sub-module, chunk_tag_delay, parameterized by LAT and the address width.

Verification
REQ-036 Scenario: NOE=19, NI=8, LAT=8, start at cycle 0 -> rd_en at cycles 1-3 (addresses 0,1,2), stage_valid at 3-5, wr_en at 11,12,13, done at 14.
REQ-037 Scenario: NOE=19 -> last-chunk wr_mask=8'b11100000, lanes 3-7 of that chunk's first_row_input and second_row_input = 0.
REQ-038 Scenario: NOE=16 -> NCH=2, both wr_mask=8'hFF, exactly 2 writes, no third chunk.
REQ-039 Scenario: start pulsed again at cycle 5 with op_in=1 during an op=0 pass -> ignored, op stays 0, write count unchanged.
REQ-040 Scenario: reset=0 asserted at cycle 9 mid-pass -> outputs zero immediately, no wr_en or done afterwards, new start after release completes normally.
REQ-041 Scenario: constant_in=64'h3F800000_00000000 latched, constant_in changed after start -> constant output holds 64'h3F800000_00000000 for the whole pass.
